// File: rtl/core_config_pkg.sv
// Shared core configuration: ALU command encoding, CSR unit state type and
// CSR address classification helpers.
package core_config_pkg;

  typedef enum logic [4:0] {
    c_NOP    = 5'd0,
    c_ADD    = 5'd1,
    c_SUB    = 5'd2,
    c_AND    = 5'd3,
    c_OR     = 5'd4,
    c_XOR    = 5'd5,
    c_SLL    = 5'd6,
    c_SRL    = 5'd7,
    c_SRA    = 5'd8,
    c_SLT    = 5'd9,
    c_SLTU   = 5'd10,
    c_CSRRW  = 5'd11,
    c_CSRRS  = 5'd12,
    c_CSRRC  = 5'd13,
    c_CSRRWI = 5'd14,
    c_CSRRSI = 5'd15,
    c_CSRRCI = 5'd16
  } alu_commands_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } csr_state_t;

  // The top two address bits equal to 2'b11 mark the read-only CSR space.
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return (addr[11:10] == 2'b11);
  endfunction

  function automatic logic csr_is_op(input alu_commands_t c);
    return (c == c_CSRRW)  || (c == c_CSRRS)  || (c == c_CSRRC) ||
           (c == c_CSRRWI) || (c == c_CSRRSI) || (c == c_CSRRCI);
  endfunction

  function automatic logic csr_is_imm(input alu_commands_t c);
    return (c == c_CSRRWI) || (c == c_CSRRSI) || (c == c_CSRRCI);
  endfunction

  function automatic logic csr_is_wr_form(input alu_commands_t c);
    return (c == c_CSRRW) || (c == c_CSRRWI);
  endfunction

endpackage

// File: rtl/csr_wdata_gen.sv
// Write-data merge for CSR operations: replace, set bits or clear bits of the
// old CSR value with the source operand.
module csr_wdata_gen
  import core_config_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_commands_t   op,
  input  logic [XLEN-1:0] readback,
  input  logic [XLEN-1:0] src,
  output logic [XLEN-1:0] wd
);

  always_comb begin
    wd = src;
    case (op)
      c_CSRRS, c_CSRRSI: wd = readback | src;
      c_CSRRC, c_CSRRCI: wd = readback & ~src;
      default:           wd = src;
    endcase
  end

endmodule

// File: rtl/csr_unit.sv
// Zicsr execution unit: sequences a handshaked CSR read, an optional write,
// and holds the old value (or an access fault) until the pipeline clears it.
module csr_unit
  import core_config_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12,
  parameter int REG_ADDR_W = 5,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  alu_commands_t         cmd,
  input  logic [XLEN-1:0]       arg0,
  input  logic [REG_ADDR_W-1:0] rs1_idx,
  input  logic [XLEN-1:0]       imm,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  clear,
  output logic                  busy,
  output logic                  i_error,
  output logic [XLEN-1:0]       res,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic                  valid,
  output logic                  o_error,
  output logic                  csr_re,
  output logic [CSR_ADDR_W-1:0] csr_ra,
  input  logic                  csr_rvalid,
  input  logic [XLEN-1:0]       csr_rd,
  output logic                  csr_we,
  output logic [CSR_ADDR_W-1:0] csr_wa,
  output logic [XLEN-1:0]       csr_wd,
  input  logic                  csr_err
);

  localparam int TMO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

  csr_state_t            state_q, state_d;
  alu_commands_t         op_q, op_d;
  logic [XLEN-1:0]       src_q, src_d;
  logic [CSR_ADDR_W-1:0] addr_q, addr_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  do_rd_q, do_rd_d;
  logic                  do_wr_q, do_wr_d;
  logic                  ro_q, ro_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic                  accept;
  logic [XLEN-1:0]       src_in;
  logic                  do_rd_in, do_wr_in, ro_in;
  logic [XLEN-1:0]       wd_merged;
  logic                  unused_imm;

  assign unused_imm = ^imm[XLEN-1:CSR_ADDR_W];

  // Decode of the incoming instruction, only consumed on accept.
  assign src_in   = csr_is_imm(cmd) ? {{(XLEN-REG_ADDR_W){1'b0}}, rs1_idx} : arg0;
  assign do_rd_in = !(csr_is_wr_form(cmd) && (i_rd == '0));
  assign do_wr_in = csr_is_wr_form(cmd) || (rs1_idx != '0);
  assign ro_in    = csr_is_ro(imm[11:0]);
  assign accept   = (state_q == IDLE) && csr_is_op(cmd) && !clear;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    do_rd_d = do_rd_q;
    do_wr_d = do_wr_q;
    ro_d    = ro_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (accept) begin
          op_d    = cmd;
          src_d   = src_in;
          addr_d  = imm[CSR_ADDR_W-1:0];
          rd_d    = i_rd;
          do_rd_d = do_rd_in;
          do_wr_d = do_wr_in;
          ro_d    = ro_in;
          // Without a read only a W form is possible, so the RO fault is known now.
          if (do_rd_in)   state_d = READ;
          else if (ro_in) state_d = ERR;
          else            state_d = WRITE;
        end
      end
      READ: begin
        if (clear) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else if (csr_rvalid) begin
          rdata_d = csr_rd;
          tmo_d   = '0;
          if (csr_err)              state_d = ERR;
          else if (do_wr_q && ro_q) state_d = ERR;
          else if (do_wr_q)         state_d = WRITE;
          else                      state_d = DONE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERR;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WRITE: begin
        if (clear)        state_d = IDLE;
        else if (csr_err) state_d = ERR;
        else              state_d = DONE;
      end
      DONE, ERR: begin
        if (clear) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= c_NOP;
      src_q   <= '0;
      addr_q  <= '0;
      rd_q    <= '0;
      do_rd_q <= 1'b0;
      do_wr_q <= 1'b0;
      ro_q    <= 1'b0;
      rdata_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      do_rd_q <= do_rd_d;
      do_wr_q <= do_wr_d;
      ro_q    <= ro_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
    end
  end

  csr_wdata_gen #(.XLEN(XLEN)) u_wdata (
    .op       (op_q),
    .readback (rdata_q),
    .src      (src_q),
    .wd       (wd_merged)
  );

  assign busy    = (state_q != IDLE);
  assign i_error = !csr_is_op(cmd);
  assign csr_re  = (state_q == READ);
  assign csr_ra  = (state_q == READ) ? addr_q : '0;
  assign csr_we  = (state_q == WRITE);
  assign csr_wa  = (state_q == WRITE) ? addr_q : '0;
  assign csr_wd  = (state_q == WRITE) ? wd_merged : '0;
  assign valid   = (state_q == DONE) || (state_q == ERR);
  assign o_error = (state_q == ERR);
  assign res     = ((state_q == DONE) && do_rd_q) ? rdata_q : '0;
  assign o_rd    = (state_q == DONE) ? rd_q : '0;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: behavioural CSR file plus a per-cycle
// monitor checking strobes and results against a transaction-level model.
module tb_csr_unit;
  import core_config_pkg::*;

  localparam int XLEN = 32, CSR_ADDR_W = 12, REG_ADDR_W = 5, RD_TIMEOUT = 16;

  logic clk, rst_n, clear;
  alu_commands_t cmd;
  logic [31:0] arg0, imm, res, csr_rd, csr_wd;
  logic [4:0]  rs1_idx, i_rd, o_rd;
  logic        busy, i_error, valid, o_error, csr_re, csr_rvalid, csr_we, csr_err;
  logic [11:0] csr_ra, csr_wa;

  csr_unit #(.XLEN(XLEN), .CSR_ADDR_W(CSR_ADDR_W), .REG_ADDR_W(REG_ADDR_W),
             .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .arg0(arg0), .rs1_idx(rs1_idx),
    .imm(imm), .i_rd(i_rd), .clear(clear), .busy(busy), .i_error(i_error),
    .res(res), .o_rd(o_rd), .valid(valid), .o_error(o_error),
    .csr_re(csr_re), .csr_ra(csr_ra), .csr_rvalid(csr_rvalid), .csr_rd(csr_rd),
    .csr_we(csr_we), .csr_wa(csr_wa), .csr_wd(csr_wd), .csr_err(csr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [31:0] mem [0:4095];

  // Model expectations for the transaction in flight.
  logic        exp_rd = 1'b0, exp_wr = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_wd = '0, exp_res = '0;
  logic [4:0]  exp_ord = '0;
  logic [11:0] exp_addr = '0;
  int          we_cnt = 0, re_cnt = 0;
  logic [31:0] seen_wd = '0, seen_res = '0;

  int   rd_delay = -1;
  logic err_rd = 1'b0, err_wr = 1'b0;
  int   rcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic tb_is_csr(input alu_commands_t c);
    case (c)
      c_CSRRW, c_CSRRS, c_CSRRC, c_CSRRWI, c_CSRRSI, c_CSRRCI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // CSR file: answers reads after rd_delay READ cycles (never if negative).
  always begin
    @(negedge clk);
    if (!csr_re) rcnt = 0;
    csr_rvalid = csr_re && (rd_delay >= 0) && (rcnt == rd_delay);
    csr_rd     = csr_rvalid ? mem[csr_ra] : 32'h0;
    csr_err    = (csr_rvalid && err_rd) || (csr_we && err_wr);
    if (csr_re) rcnt++;
    if (csr_we && !err_wr) mem[csr_wa] = csr_wd;
  end

  // Per-cycle monitor.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      chk("i_error", i_error, !tb_is_csr(cmd));
      if (csr_we) begin
        we_cnt++;
        seen_wd = csr_wd;
        chk("we_expected", exp_wr, 1);
        chk("csr_wa", csr_wa, exp_addr);
        chk("csr_wd", csr_wd, exp_wd);
      end else begin
        chk("wa_idle", csr_wa, 0);
        chk("wd_idle", csr_wd, 0);
      end
      if (csr_re) begin
        re_cnt++;
        chk("re_expected", exp_rd, 1);
        chk("csr_ra", csr_ra, exp_addr);
      end else begin
        chk("ra_idle", csr_ra, 0);
      end
      if (valid) begin
        seen_res = res;
        chk("o_error", o_error, exp_err);
        chk("res", res, exp_res);
        chk("o_rd", o_rd, exp_ord);
      end
    end
  end

  task automatic run_op(input string nm, input alu_commands_t op, input logic [31:0] a0,
                        input logic [4:0] r1, input logic [11:0] addr, input logic [4:0] rd,
                        input int delay, input logic erd, input logic ewr, output int lat);
    logic w, s, im, drd, dwr, ro, tmo;
    logic [31:0] src, old;
    im  = (op == c_CSRRWI) || (op == c_CSRRSI) || (op == c_CSRRCI);
    w   = (op == c_CSRRW) || (op == c_CSRRWI);
    s   = (op == c_CSRRS) || (op == c_CSRRSI);
    src = im ? {27'd0, r1} : a0;
    drd = !(w && rd == 5'd0);
    dwr = w || (r1 != 5'd0);
    ro  = (addr[11:10] == 2'b11);
    old = mem[addr];
    tmo = (delay < 0) || (delay > RD_TIMEOUT - 1);
    exp_addr = addr; exp_rd = drd; exp_wr = 0; exp_wd = 0;
    exp_err = 0; exp_res = 0; exp_ord = rd;
    if (!drd) begin
      if (ro) exp_err = 1;
      else begin exp_wr = 1; exp_wd = src; exp_err = ewr; end
    end else if (tmo || erd || (dwr && ro)) begin
      exp_err = 1;
    end else begin
      exp_res = old;
      if (dwr) begin
        exp_wr = 1;
        exp_wd = w ? src : (s ? (old | src) : (old & ~src));
        exp_err = ewr;
      end
    end
    if (exp_err) begin exp_res = 0; exp_ord = 0; end
    rd_delay = delay; err_rd = erd; err_wr = ewr;
    we_cnt = 0; re_cnt = 0; seen_wd = 0; seen_res = 0;
    @(negedge clk);
    cmd = op; arg0 = a0; rs1_idx = r1; imm = {20'd0, addr}; i_rd = rd;
    @(negedge clk);
    cmd = c_NOP; arg0 = 0; rs1_idx = 0; imm = 0; i_rd = 0;
    #2;
    chk({nm, "_busy"}, busy, 1);
    lat = 1;
    while (!valid && lat < 100) begin
      @(negedge clk); #2; lat++;
    end
    chk({nm, "_valid"}, valid, 1);
    @(negedge clk); #2;
    chk({nm, "_hold"}, valid, 1);
    clear = 1;
    @(negedge clk);
    clear = 0;
    #2;
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_valid"}, valid, 0);
    chk({nm, "_we_cnt"}, we_cnt, exp_wr ? 1 : 0);
    chk({nm, "_read"}, re_cnt != 0, exp_rd);
    exp_rd = 0; exp_wr = 0;
    rd_delay = -1; err_rd = 0; err_wr = 0;
  endtask

  int lat;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5A000000 | i;
    mem[12'h300] = 32'h1800;
    rst_n = 0; clear = 0; cmd = c_NOP; arg0 = 0; rs1_idx = 0; imm = 0; i_rd = 0;
    csr_rvalid = 0; csr_rd = 0; csr_err = 0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_res", res, 0);
    chk("rst_re", csr_re, 0);
    chk("rst_we", csr_we, 0);
    chk("rst_oerr", o_error, 0);
    @(negedge clk);
    rst_n = 1;

    run_op("t1_csrrs", c_CSRRS, 32'h8, 5'd3, 12'h300, 5'd5, 3, 0, 0, lat);
    chk("t1_lat", lat, 6);
    chk("t1_wd_lit", seen_wd, 32'h1808);
    chk("t1_res_lit", seen_res, 32'h1800);
    chk("t1_mem", mem[12'h300], 32'h1808);

    run_op("t2_csrrw_x0", c_CSRRW, 32'hDEADBEEF, 5'd1, 12'h340, 5'd0, 0, 0, 0, lat);
    chk("t2_lat", lat, 2);
    chk("t2_no_read", re_cnt, 0);
    chk("t2_wd_lit", seen_wd, 32'hDEADBEEF);
    chk("t2_res_lit", seen_res, 0);

    run_op("t3_csrrci0", c_CSRRCI, 32'h0, 5'd0, 12'h300, 5'd7, 0, 0, 0, lat);
    chk("t3_lat", lat, 2);
    chk("t3_res_lit", seen_res, 32'h1808);
    chk("t3_no_write", we_cnt, 0);

    run_op("t4_ro_write", c_CSRRW, 32'h1234, 5'd2, 12'hC00, 5'd1, 1, 0, 0, lat);
    chk("t4_lat", lat, 3);
    chk("t4_reads", re_cnt, 2);

    run_op("t5_timeout", c_CSRRS, 32'h1, 5'd1, 12'h305, 5'd2, -1, 0, 0, lat);
    chk("t5_lat", lat, 17);
    chk("t5_read_cycles", re_cnt, 16);

    run_op("t6_rd_err", c_CSRRS, 32'h1, 5'd1, 12'h301, 5'd3, 0, 1, 0, lat);
    chk("t6_lat", lat, 2);

    run_op("t7_wr_err", c_CSRRWI, 32'h0, 5'd9, 12'h341, 5'd0, 0, 0, 1, lat);
    chk("t7_lat", lat, 2);
    chk("t7_mem_kept", mem[12'h341], 32'h5A000341);

    run_op("t8_csrrsi", c_CSRRSI, 32'h0, 5'd5, 12'h342, 5'd4, 1, 0, 0, lat);
    chk("t8_lat", lat, 4);
    chk("t8_wd_lit", seen_wd, 32'h5A000347);

    run_op("t9_csrrc", c_CSRRC, 32'hFF00, 5'd2, 12'h343, 5'd6, 0, 0, 0, lat);
    chk("t9_wd_lit", seen_wd, 32'h5A000043);

    run_op("t10_csrrw", c_CSRRW, 32'h12345678, 5'd1, 12'h344, 5'd8, 2, 0, 0, lat);
    chk("t10_lat", lat, 5);
    chk("t10_res_lit", seen_res, 32'h5A000344);

    run_op("t11_ro_nord", c_CSRRWI, 32'h0, 5'd4, 12'hC01, 5'd0, 0, 0, 0, lat);
    chk("t11_lat", lat, 1);
    chk("t11_no_read", re_cnt, 0);

    // Clear while waiting for read data aborts without writing.
    exp_addr = 12'h300; exp_rd = 1; exp_wr = 0; we_cnt = 0; rd_delay = -1;
    @(negedge clk);
    cmd = c_CSRRS; rs1_idx = 5'd3; arg0 = 32'h4; imm = 32'h300; i_rd = 5'd5;
    @(negedge clk);
    cmd = c_NOP; rs1_idx = 0; arg0 = 0; imm = 0; i_rd = 0;
    #2 chk("clr_rd_in_read", csr_re, 1);
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    #2;
    chk("clr_rd_idle", busy, 0);
    repeat (3) @(negedge clk);
    #2 chk("clr_rd_no_we", we_cnt, 0);
    exp_rd = 0;

    // Unknown command is flagged and never accepted.
    @(negedge clk);
    cmd = c_ADD;
    #2 chk("unk_ierr", i_error, 1);
    @(negedge clk);
    #2 chk("unk_busy", busy, 0);
    cmd = c_NOP;

    // Clear in IDLE blocks accept.
    @(negedge clk);
    cmd = c_CSRRW; imm = 32'h340; i_rd = 0; arg0 = 32'h1; clear = 1;
    @(negedge clk);
    cmd = c_NOP; imm = 0; arg0 = 0; clear = 0;
    #2 chk("clr_idle_block", busy, 0);

    // Reset in the middle of a read.
    exp_addr = 12'h300; exp_rd = 1; exp_wr = 0; we_cnt = 0; rd_delay = -1;
    @(negedge clk);
    cmd = c_CSRRS; rs1_idx = 5'd1; arg0 = 32'h1; imm = 32'h300; i_rd = 5'd2;
    @(negedge clk);
    cmd = c_NOP; rs1_idx = 0; arg0 = 0; imm = 0; i_rd = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_re", csr_re, 0);
    chk("mrst_valid", valid, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    #2;
    chk("mrst_idle", busy, 0);
    chk("mrst_no_we", we_cnt, 0);
    exp_rd = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised CSR execution unit for the RV32 core. Executes all six Zicsr operations: CSRRW/S/C and the immediate forms CSRRWI/SI/CI.
- Talks to the CSR file over a read request/valid handshake, so CSR read latency may be variable.
- Implements the architectural read/write suppression rules, read-only CSR protection and a read timeout.
- Sits in the execute stage beside the other ALUs. Same result/valid/clear retirement contract.

Parameters:
- XLEN, 32, data width.
- CSR_ADDR_W, 12, CSR address width.
- REG_ADDR_W, 5, register index width.
- RD_TIMEOUT, 16, cycles in READ without csr_rvalid before a timeout error. Minimum 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd  in  alu_commands_t  operation. Non-CSR values are ignored.
- arg0  in  XLEN  rs1 value.
- rs1_idx  in  REG_ADDR_W  rs1 index, also the zero-extended uimm for the I forms.
- imm  in  XLEN  instruction immediate. Bits [CSR_ADDR_W-1:0] are the CSR address.
- i_rd  in  REG_ADDR_W  destination index.
- clear  in  1  retire/flush acknowledge.
- busy  out  1  unit occupied.
- i_error  out  1  combinational: cmd is not a CSR op.
- res  out  XLEN  old CSR value.
- o_rd  out  REG_ADDR_W  destination index.
- valid  out  1  result or error held.
- o_error  out  1  access fault held.
- csr_re  out  1  read request.
- csr_ra  out  CSR_ADDR_W  read address.
- csr_rvalid  in  1  read data valid.
- csr_rd  in  XLEN  read data.
- csr_we  out  1  write strobe.
- csr_wa  out  CSR_ADDR_W  write address.
- csr_wd  out  XLEN  write data.
- csr_err  in  1  CSR file fault, sampled with csr_rvalid or csr_we.

Behaviour:
- Reset: state IDLE. All outputs 0. Internal registers and the timeout counter 0.
- Operand: src = arg0 for register forms; src = zero-extended rs1_idx for I forms.
- Flags:
  - do_rd = !(CSRRW/CSRRWI and i_rd==0).
  - do_wr = CSRRW/CSRRWI, or (S/C forms and rs1_idx!=0).
  - ro = (addr[11:10]==2'b11).
- Accept: only when state==IDLE, cmd is a CSR op and clear==0. On accept, latch op, src, addr, rd, do_rd, do_wr, ro.
  - Next state: READ if do_rd, else WRITE (CSRRW/CSRRWI with rd=x0 issues no read).
- READ:
  - csr_re=1 and csr_ra=addr, held until csr_rvalid.
  - The timeout counter increments each cycle in READ.
  - On csr_rvalid: latch readback=csr_rd.
    - If csr_err -> ERR.
    - Else if do_wr and ro -> ERR (no write issued).
    - Else if do_wr -> WRITE.
    - Else -> DONE.
  - Counter reaching RD_TIMEOUT-1 without rvalid -> ERR.
- WRITE:
  - One cycle: csr_we=1, csr_wa=addr.
  - csr_wd by op:
    - W forms: src.
    - S forms: readback|src.
    - C forms: readback&~src.
  - The !do_rd path only exists for W forms, so readback is never used uninitialised.
  - A read-only address with !do_rd -> ERR instead of WRITE, checked at accept.
  - csr_err in this cycle -> ERR, else DONE.
- DONE: valid=1, res=readback (0 if !do_rd), o_rd=rd. Held until clear, then IDLE.
- ERR: valid=1, o_error=1, res=0, o_rd=0. Held until clear, then IDLE.
- busy = (state!=IDLE).
- All csr_* outputs are 0 outside READ and WRITE.
- Clear in READ: abort, go to IDLE, no write.
- Clear in WRITE: the strobe still fires that cycle (already committed), then IDLE.
- Clear in IDLE: blocks accept.
- Latency, CSRRS with rvalid on the first READ cycle: accept T, READ T+1, valid T+2.
- Latency, CSRRW to x0: accept T, WRITE T+1, valid T+2.
- Reset mid-operation: immediate return to IDLE. An in-flight write is dropped unless csr_we was already sampled.

Decomposition:
- core_config_pkg:
  - add c_CSRRWI, c_CSRRSI, c_CSRRCI to alu_commands_t.
  - add csr_state_t (IDLE, READ, WRITE, DONE, ERR).
  - add function csr_is_ro(addr).
- Sub-module csr_wdata_gen: combinational write-data merge (op, readback, src -> wd). Reusable by a future multi-port CSR unit.

Test Plan:
- CSRRS x5, mstatus(0x300), arg0=0x8, rs1_idx=3, CSR=0x1800; rvalid after 3 cycles -> csr_wd=0x1808 with csr_we for exactly one cycle; res=0x1800, o_rd=5, valid held until clear.
- CSRRW x0, 0x340, arg0=0xDEADBEEF -> csr_re never asserted; WRITE at T+1, csr_wd=0xDEADBEEF; valid at T+2, res=0.
- CSRRCI x7, 0x300, uimm=0 -> no write; res=CSR value; csr_we stays 0 throughout.
- CSRRW to 0xC00 (cycle, read-only) with i_rd=1 -> read occurs; no csr_we; o_error=1, valid=1 until clear.
- RD_TIMEOUT=16, csr_rvalid held low -> ERR after 16 READ cycles. Separately: csr_err=1 with rvalid -> ERR, no write.
- clear asserted during READ -> IDLE next cycle, csr_we never asserted. Unknown cmd -> i_error=1 and state stays IDLE.
